// File: rtl/pe_pkg.sv
// Shared types and defaults for the processing-element sequencer.
package pe_pkg;

   localparam int unsigned DEF_K_W      = 8;
   localparam int unsigned DEF_P_W      = 4;
   localparam int unsigned DEF_MULT_LAT = 2;

   // fifo_C mux select encodings
   localparam logic C_SEL_LOCAL = 1'b0;
   localparam logic C_SEL_PASS  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_FLUSH,
      S_WRITE,
      S_PASS,
      S_DONE
   } pe_state_t;

endpackage

// File: rtl/pe_ctrl_if.sv
// Job, operand-FIFO, accumulator and fifo_C control bundle for one PE.
interface pe_ctrl_if
   import pe_pkg::*;
#(
   parameter int unsigned K_W = DEF_K_W,
   parameter int unsigned P_W = DEF_P_W
);
   logic           start;
   logic [K_W-1:0] k_len;
   logic [P_W-1:0] pass_len;
   logic           busy;
   logic           done;
   logic           a_empty;
   logic           b_empty;
   logic           a_rd;
   logic           b_rd;
   logic           reg_ld;
   logic           acc_clr;
   logic           acc_en;
   logic           c_sel;
   logic           c_in_valid;
   logic           c_in_rd;
   logic           c_full;
   logic           c_wr;

   modport slave (
      input  start, k_len, pass_len, a_empty, b_empty, c_in_valid, c_full,
      output busy, done, a_rd, b_rd, reg_ld, acc_clr, acc_en, c_sel,
             c_in_rd, c_wr
   );

   modport master (
      output start, k_len, pass_len, a_empty, b_empty, c_in_valid, c_full,
      input  busy, done, a_rd, b_rd, reg_ld, acc_clr, acc_en, c_sel,
             c_in_rd, c_wr
   );

endinterface

// File: rtl/pe_ctrl_pipe.sv
// Valid delay line tracking operand pops through RA/RB and the multiplier.
module pe_ctrl_pipe
   import pe_pkg::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic in_vld,
   input  logic in_first,
   output logic reg_ld,
   output logic acc_en,
   output logic acc_clr,
   output logic empty
);
   localparam int unsigned DEPTH = 1 + MULT_LAT;

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] first_q, first_d;

   // shift pop valid and first-product marker one stage per cycle
   always_comb begin
      vld_d   = {vld_q[DEPTH-2:0], in_vld};
      first_d = {first_q[DEPTH-2:0], in_vld & in_first};
   end

   // delay-line registers, flushed on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         first_q <= '0;
      end else begin
         vld_q   <= vld_d;
         first_q <= first_d;
      end
   end

   // stage 0 loads RA/RB, last stage is product valid at Mem_C
   always_comb begin
      reg_ld  = vld_q[0];
      acc_en  = vld_q[DEPTH-1];
      acc_clr = first_q[DEPTH-1];
      empty   = ~|vld_q;
   end

endmodule

// File: rtl/pe_ctrl.sv
// Local sequencer for one systolic-array PE: MAC issue, flush, result write, pass-through.
module pe_ctrl
   import pe_pkg::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned K_W      = DEF_K_W,
   parameter int unsigned P_W      = DEF_P_W
) (
   input logic        clk,
   input logic        rst,
   pe_ctrl_if.slave   bus
);
   pe_state_t      state_q, state_d;
   logic [K_W-1:0] k_len_q, k_len_d;
   logic [K_W-1:0] issue_q, issue_d;
   logic [P_W-1:0] pass_len_q, pass_len_d;
   logic [P_W-1:0] pass_cnt_q, pass_cnt_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           c_sel_q, c_sel_d;
   logic           pop, first_pop, wr, in_rd;
   logic           pipe_empty, pipe_reg_ld, pipe_acc_en, pipe_acc_clr;

   pe_ctrl_pipe #(.MULT_LAT(MULT_LAT)) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (pop),
      .in_first (first_pop),
      .reg_ld   (pipe_reg_ld),
      .acc_en   (pipe_acc_en),
      .acc_clr  (pipe_acc_clr),
      .empty    (pipe_empty)
   );

   // next state, counters and same-cycle FIFO strobes
   always_comb begin
      state_d    = state_q;
      k_len_d    = k_len_q;
      issue_d    = issue_q;
      pass_len_d = pass_len_q;
      pass_cnt_d = pass_cnt_q;
      pop        = 1'b0;
      first_pop  = 1'b0;
      wr         = 1'b0;
      in_rd      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               k_len_d    = bus.k_len;
               pass_len_d = bus.pass_len;
               issue_d    = '0;
               pass_cnt_d = '0;
               if (bus.k_len != '0)         state_d = S_MAC;
               else if (bus.pass_len != '0) state_d = S_PASS;
               else                         state_d = S_DONE;
            end
         end
         S_MAC: begin
            pop       = !bus.a_empty && !bus.b_empty;
            first_pop = (issue_q == '0);
            if (pop) begin
               issue_d = issue_q + 1'b1;
               if (issue_d == k_len_q) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // empty delay line here means the last product already reached Mem_C
            if (pipe_empty) state_d = S_WRITE;
         end
         S_WRITE: begin
            wr = !bus.c_full;
            if (wr) state_d = (pass_len_q != '0) ? S_PASS : S_DONE;
         end
         S_PASS: begin
            wr    = bus.c_in_valid && !bus.c_full;
            in_rd = wr;
            if (wr) begin
               pass_cnt_d = pass_cnt_q + 1'b1;
               if (pass_cnt_d == pass_len_q) state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      c_sel_d = (state_d == S_PASS) ? C_SEL_PASS : C_SEL_LOCAL;
   end

   // state and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         k_len_q    <= '0;
         issue_q    <= '0;
         pass_len_q <= '0;
         pass_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         c_sel_q    <= C_SEL_LOCAL;
      end else begin
         state_q    <= state_d;
         k_len_q    <= k_len_d;
         issue_q    <= issue_d;
         pass_len_q <= pass_len_d;
         pass_cnt_q <= pass_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         c_sel_q    <= c_sel_d;
      end
   end

   // drive the interface
   always_comb begin
      bus.a_rd    = pop;
      bus.b_rd    = pop;
      bus.c_wr    = wr;
      bus.c_in_rd = in_rd;
      bus.reg_ld  = pipe_reg_ld;
      bus.acc_en  = pipe_acc_en;
      bus.acc_clr = pipe_acc_clr;
      bus.busy    = busy_q;
      bus.done    = done_q;
      bus.c_sel   = c_sel_q;
   end

endmodule

// File: doc/pe_ctrl.md
# pe_ctrl

Local sequencer for one processing element of the CNN accelerator systolic array. It pops operand pairs from the A/B FIFOs, loads RA/RB, and tracks products through the multiplier so it can clear and enable the Mem_C accumulator at the right cycles. After the dot product completes it writes the local result into fifo_C, then switches the C mux to forward upstream partial results. It drives control signals only; no data passes through it.

## Interface

Parameters:

- MULT_LAT, 2, multiplier latency in cycles, RA/RB valid to C_inter valid (≥1)
- K_W, 8, width of dot-product length
- P_W, 4, width of pass-through count

Ports:

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- k_len  in  K_W  number of A/B pairs to accumulate; latched on start
- pass_len  in  P_W  number of upstream C words to forward; latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on job completion
- a_empty, b_empty  in  1  operand FIFO empty flags
- a_rd, b_rd  out  1  pop operand FIFOs; data is valid the next cycle
- reg_ld  out  1  load RA/RB (drives input_en)
- acc_clr  out  1  with acc_en: Mem_C takes the product and ignores prev_result
- acc_en  out  1  C_inter valid this cycle; accumulate into Mem_C
- c_sel  out  1  fifo_C mux select: 0 = add_out, 1 = input_C
- c_in_valid  in  1  upstream C word available
- c_in_rd  out  1  consume upstream C word
- c_full  in  1  fifo_C full
- c_wr  out  1  push into fifo_C

## Operation

- States: IDLE, MAC, FLUSH, WRITE, PASS, DONE.
- IDLE:
  - start with k_len≠0 → MAC.
  - start with k_len=0 and pass_len≠0 → PASS.
  - start with both zero → DONE.
  - Latch k_len and pass_len on start; clear the issue count.
- MAC: a_rd = b_rd = !a_empty && !b_empty. Each pop increments the issue count. The pop that brings the count to k_len → FLUSH. Either FIFO empty means a stall with no pop; no partial pops.
- Operand delay line:
  - reg_ld = pop delayed 1 cycle.
  - acc_en = reg_ld delayed MULT_LAT cycles.
  - acc_clr = acc_en on the first product of the job only.
- FLUSH: wait until the delay line is empty, plus 1 cycle for the adder/Mem_C write, then → WRITE.
- WRITE: c_sel=0; c_wr = !c_full. When the write happens: → PASS if pass_len≠0, else → DONE.
- PASS: c_sel=1; c_in_rd = c_wr = c_in_valid && !c_full. Count transfers; the pass_len-th transfer → DONE.
- DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- k_len=0 produces no fifo_C write of a local result.

## Timing

- Reset values: all outputs 0 (c_sel=0, busy=0); state IDLE; delay line and counters cleared.
- rst asserted mid-job: next edge is IDLE with the delay line flushed. There is no done pulse. Any in-flight acc_en is dropped; Mem_C contents are undefined until the next acc_clr.
- Output timing:
  - a_rd, b_rd, c_wr, c_in_rd: combinational from registered state and the same-cycle flags.
  - reg_ld, acc_en, acc_clr, c_sel, busy, done: registered.
- Fixed latencies:
  - Pop at cycle t → reg_ld at t+1 → acc_en at t+1+MULT_LAT.
  - Last acc_en at cycle u → earliest c_wr at u+2.
- Full-rate MAC (FIFOs never empty): first c_wr at cycle s+k_len+MULT_LAT+3, where s is the start-sampled edge.
- c_full held high stalls WRITE/PASS indefinitely; no word is lost or duplicated.
- Count width rule: the issue counter is K_W bits and compares against the latched k_len. No wrap for k_len = 2^K_W−1.

## Structure

- Shared package pe_pkg holds:
  - state enum pe_state_t
  - default widths (K_W, P_W, MULT_LAT)
  - c_sel encodings C_SEL_LOCAL=0, C_SEL_PASS=1
- Sub-module pe_ctrl_pipe: a parameterized valid delay line (depth 1+MULT_LAT). It outputs reg_ld, acc_en, acc_clr (first flag carried with valid) and an all-empty flag used by FLUSH.

## Test plan

- k_len=3, pass_len=0, FIFOs full, MULT_LAT=2 → pops at s+1..s+3, reg_ld s+2..s+4, acc_en s+4..s+6 with acc_clr only at s+4, c_wr(c_sel=0) at s+8, done at s+9.
- k_len=4, a_empty high for 3 cycles after the 2nd pop → exactly 4 pops; acc_en count 4; the c_wr slips by 3 cycles.
- k_len=2, pass_len=2, c_full high for 5 cycles in WRITE then in PASS; c_in_valid toggling → 1 local write with c_sel=0, then exactly 2 forwarded writes with c_sel=1; c_in_rd pulses equal c_wr pulses.
- k_len=0, pass_len=0 → busy for 1 cycle, done pulse, no a_rd/acc_en/c_wr.
- start re-pulsed during MAC → ignored; counts unaffected.
- rst asserted 2 cycles into MAC with the delay line loaded → next cycle all outputs 0, state IDLE, no later acc_en or done. A fresh start with k_len=1 then produces acc_clr on its product.
